// File: rtl/west_edge_issuer.sv
// West-edge instruction/activation issuer for the systolic MAC array.
// Issues one burst per command and skews it so row r sees it r cycles late.
module west_edge_issuer #(
  parameter int row        = 8,
  parameter int bw         = 4,
  parameter int inst_width = 4,
  parameter int len_bw     = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [1:0]                  mode,
  input  logic [len_bw-1:0]           len,
  input  logic [row*bw-1:0]           in_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic [row*bw-1:0]           out_w,
  output logic [row*inst_width-1:0]   inst_w,
  output logic                        busy,
  output logic                        done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int DRAIN_LAST = (row > 1) ? row - 2 : 0;

  state_t                state_q, state_d;
  logic [1:0]            mode_q, mode_d;
  logic [len_bw-1:0]     len_q, len_d;
  logic [len_bw-1:0]     issue_cnt_q, issue_cnt_d;
  logic [len_bw-1:0]     drain_cnt_q, drain_cnt_d;
  logic                  in_ready_q, in_ready_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [inst_width-1:0] inst0_d;
  logic [row*bw-1:0]     data0_d;
  logic                  load;

  // Each skew stage holds the whole vector; row r only taps its own slice.
  logic [inst_width-1:0] inst_q [row];
  logic [row*bw-1:0]     data_q [row];

  function automatic logic is_data_mode(input logic [1:0] m);
    return (m == 2'd1) || (m == 2'd2);
  endfunction

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    len_d       = len_q;
    issue_cnt_d = issue_cnt_q;
    drain_cnt_d = drain_cnt_q;
    inst0_d     = '0;
    data0_d     = '0;
    load        = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          mode_d      = mode;
          len_d       = len;
          issue_cnt_d = '0;
          state_d     = (len == '0) ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        load = is_data_mode(mode_q) ? in_valid : 1'b1;
        if (load) begin
          inst0_d     = inst_width'(1) << mode_q;
          data0_d     = is_data_mode(mode_q) ? in_data : '0;
          issue_cnt_d = issue_cnt_q + 1'b1;
          if (issue_cnt_q == len_q - 1'b1) begin
            drain_cnt_d = '0;
            state_d     = (row > 1) ? DRAIN : DONE;
          end
        end
      end
      DRAIN: begin
        drain_cnt_d = drain_cnt_q + 1'b1;
        if (drain_cnt_q == len_bw'(DRAIN_LAST)) state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Status outputs are registered from the next state so they align with state_q.
    busy_d     = (state_d != IDLE);
    done_d     = (state_d == DONE);
    in_ready_d = (state_d == ISSUE) && is_data_mode(mode_d);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      mode_q      <= '0;
      len_q       <= '0;
      issue_cnt_q <= '0;
      drain_cnt_q <= '0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      for (int r = 0; r < row; r++) begin
        inst_q[r] <= '0;
        data_q[r] <= '0;
      end
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      len_q       <= len_d;
      issue_cnt_q <= issue_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      inst_q[0]   <= inst0_d;
      data_q[0]   <= data0_d;
      for (int r = 1; r < row; r++) begin
        inst_q[r] <= inst_q[r-1];
        data_q[r] <= data_q[r-1];
      end
    end
  end

  for (genvar g = 0; g < row; g++) begin : g_row
    assign inst_w[g*inst_width +: inst_width] = inst_q[g];
    assign out_w[g*bw +: bw]                  = data_q[g][g*bw +: bw];
  end

  assign in_ready = in_ready_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule
